seq_mult_param: RTL and testbench

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

---
 rtl/seq_mult_param.sv | 126 ++++++++++++
 tb/tb_seq_mult_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, signed/unsigned, one bit per cycle.
// Define SEQ_MULT_EARLY_EXIT_EN to end RUN once the multiplier copy empties.
module seq_mult_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             smode_q, smode_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] a_mag, b_mag, mplier_sh;
    logic [PW-1:0]    acc_sum, res;
    logic [WIDTH:0]   hi_s;
    logic             last;

    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude
    assign a_mag = (is_signed && multiplier[WIDTH-1])
                 ? ({WIDTH{1'b0}} - multiplier) : multiplier;
    assign b_mag = (is_signed && multiplicand[WIDTH-1])
                 ? ({WIDTH{1'b0}} - multiplicand) : multiplicand;

    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
    assign mplier_sh = mplier_q >> 1;
    assign res       = neg_q ? ({PW{1'b0}} - acc_sum) : acc_sum;
    assign hi_s      = res[PW-1:WIDTH-1];

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign last = (cnt_q == CNT_W'(1)) || (mplier_sh == {WIDTH{1'b0}});
`else
    assign last = (cnt_q == CNT_W'(1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        smode_d  = smode_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_RUN: begin
                acc_d    = acc_sum;
                mplier_d = mplier_sh;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = S_DONE;
                    prod_d  = res;
                    ovf_d   = smode_q ? ~((&hi_s) || ~(|hi_s))
                                      : (|res[PW-1:WIDTH]);
                end
            end
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mplier_d = a_mag;
                    mcand_d  = {{WIDTH{1'b0}}, b_mag};
                    acc_d    = {PW{1'b0}};
                    cnt_d    = CNT_W'(WIDTH);
                    neg_d    = is_signed
                             & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                    smode_d  = is_signed;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            smode_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            smode_q  <= smode_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: WIDTH=32 and WIDTH=8 instances against an
// arithmetic reference model, directed corner cases plus random operands.
module tb_seq_mult_param;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        st32, sg32, busy32, done32, ovf32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic        st8, sg8, busy8, done8, ovf8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(32)) u32 (
        .clk(clk), .reset_n(reset_n), .start(st32), .is_signed(sg32),
        .multiplier(a32), .multiplicand(b32), .busy(busy32),
        .done(done32), .product(p32), .ovf(ovf32)
    );

    seq_mult_param #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .start(st8), .is_signed(sg8),
        .multiplier(a8), .multiplicand(b8), .busy(busy8),
        .done(done8), .product(p8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // True product of the operands read as integers of the chosen mode
    task automatic model(input int w, input bit sgn, input logic [63:0] a,
                         input logic [63:0] b, output logic [127:0] p,
                         output logic o);
        logic [127:0] ea, eb, full;
        logic signed [127:0] sf, hi, lo;
        ea = {64'd0, a} & ((128'd1 << w) - 1);
        eb = {64'd0, b} & ((128'd1 << w) - 1);
        if (sgn && ea[w-1]) ea = ea - (128'd1 << w);
        if (sgn && eb[w-1]) eb = eb - (128'd1 << w);
        full = ea * eb;
        p    = full & ((128'd1 << (2 * w)) - 1);
        sf   = full;
        hi   = (128'd1 << (w - 1)) - 1;
        lo   = -$signed(128'd1 << (w - 1));
        if (sgn) o = (sf > hi) || (sf < lo);
        else     o = (full >= (128'd1 << w));
    endtask

    function automatic int exp_lat(input int w, input bit sgn,
                                   input logic [63:0] a);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        logic [63:0] m;
        int n;
        m = a & ((64'd1 << w) - 1);
        if (sgn && m[w-1]) m = (64'd1 << w) - m;
        n = 0;
        for (int i = 0; i < w; i++) if (m[i]) n = i + 1;
        if (n == 0) n = 1;
        return n + 1;
`else
        return w + 1;
`endif
    endfunction

    task automatic drive(input int w, input bit s, input bit sg,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 8) begin
            st8 = s; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            st32 = s; sg32 = sg; a32 = a[31:0]; b32 = b[31:0];
        end
    endtask

    task automatic sample(input int w, output logic bz, output logic dn,
                          output logic [127:0] p, output logic o);
        if (w == 8) begin
            bz = busy8; dn = done8; p = {112'd0, p8}; o = ovf8;
        end else begin
            bz = busy32; dn = done32; p = {64'd0, p32}; o = ovf32;
        end
    endtask

    // glitch>0: pulse start with other operands at that RUN cycle.
    // chain: present the next operation during the DONE cycle.
    task automatic run_op(input string tag, input int w, input bit sgn,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit pre, input int glitch, input bit chain,
                          input bit csg, input logic [63:0] ca,
                          input logic [63:0] cb);
        logic [127:0] ep, p;
        logic eo, bz, dn, o, both;
        int lat;
        model(w, sgn, a, b, ep, eo);
        if (!pre) begin
            @(negedge clk);
            drive(w, 1'b1, sgn, a, b);
        end
        @(posedge clk); #1;
        st8 = 1'b0; st32 = 1'b0;
        lat = 1;
        sample(w, bz, dn, p, o);
        check({tag, "_busy"}, {127'd0, bz}, 128'd1);
        both = 1'b0;
        while (!dn && lat < 4 * w + 20) begin
            if (lat == glitch) drive(w, 1'b1, ~sgn, ~a, ~b);
            @(posedge clk); #1;
            st8 = 1'b0; st32 = 1'b0;
            lat++;
            sample(w, bz, dn, p, o);
            if (bz && dn) both = 1'b1;
        end
        check({tag, "_done"}, {127'd0, dn}, 128'd1);
        check({tag, "_excl"}, {127'd0, both}, 128'd0);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat(w, sgn, a)));
        check({tag, "_prod"}, p, ep);
        check({tag, "_ovf"}, {127'd0, o}, {127'd0, eo});
        if (chain) drive(w, 1'b1, csg, ca, cb);
    endtask

    initial begin
        logic [127:0] p;
        logic bz, dn, o, seen;
        int w;
        bit sg;
        logic [63:0] a, b;

        reset_n = 1'b0;
        drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        sample(32, bz, dn, p, o);
        check("rst32_busy", {127'd0, bz}, 128'd0);
        check("rst32_done", {127'd0, dn}, 128'd0);
        check("rst32_prod", p, 128'd0);
        check("rst32_ovf", {127'd0, o}, 128'd0);
        sample(8, bz, dn, p, o);
        check("rst8_busy", {127'd0, bz}, 128'd0);
        check("rst8_prod", p, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("u_ff", 32, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF,
               0, 0, 0, 0, 0, 0);
        check("u_ff_const", {64'd0, p32}, 128'hFFFFFFFE00000001);
        run_op("s_m3x7", 32, 1'b1, 64'hFFFFFFFD, 64'd7, 0, 0, 0, 0, 0, 0);
        check("s_m3x7_const", {64'd0, p32}, 128'hFFFFFFFFFFFFFFEB);
        run_op("s_min2", 32, 1'b1, 64'h80000000, 64'h80000000,
               0, 0, 0, 0, 0, 0);
        check("s_min2_const", {64'd0, p32}, 128'h4000000000000000);
        run_op("w8_s", 8, 1'b1, 64'h80, 64'h01, 0, 0, 0, 0, 0, 0);
        check("w8_s_const", {112'd0, p8}, 128'hFF80);
        run_op("w8_u", 8, 1'b0, 64'h80, 64'h01, 0, 0, 0, 0, 0, 0);
        check("w8_u_const", {112'd0, p8}, 128'h0080);
        run_op("u_5x1000", 32, 1'b0, 64'd5, 64'd1000, 0, 0, 0, 0, 0, 0);
        run_op("u_zero", 32, 1'b0, 64'd0, 64'h12345678, 0, 0, 0, 0, 0, 0);

        run_op("ign", 32, 1'b1, 64'hFFFF0001, 64'h00C0FFEE, 0, 5, 1,
               1'b0, 64'hDEADBEEF, 64'h0000BEEF);
        run_op("b2b", 32, 1'b0, 64'hDEADBEEF, 64'h0000BEEF, 1, 0, 0, 0, 0, 0);
        run_op("ign8", 8, 1'b0, 64'hF3, 64'h9A, 0, 3, 1,
               1'b1, 64'h81, 64'h7F);
        run_op("b2b8", 8, 1'b1, 64'h81, 64'h7F, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        drive(32, 1'b1, 1'b0, 64'h89ABCDEF, 64'hFEDCBA98);
        @(negedge clk);
        st32 = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        sample(32, bz, dn, p, o);
        check("abort_busy", {127'd0, bz}, 128'd0);
        check("abort_done", {127'd0, dn}, 128'd0);
        check("abort_prod", p, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 !== 1'b0 || busy32 !== 1'b0) seen = 1'b1;
        end
        check("abort_quiet", {127'd0, seen}, 128'd0);
        run_op("post_rst", 32, 1'b1, 64'h7FFFFFFF, 64'h80000000,
               0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            w  = (i % 2) ? 8 : 32;
            sg = 1'($urandom % 2);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (i % 6 == 0) a = 64'd1 << (w - 1);
            if (i % 8 == 3) b = '1;
            if (i % 7 == 5) a = $urandom_range(0, 15);
            run_op($sformatf("rnd%0d", i), w, sg, a, b, 0, 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
